// File: rtl/roc_aer_sequencer.sv
// Sequences one image through the ROC encoder: start pulse, 4-phase AER drain of
// sorted indices with ACK timeouts, then waits for the core's inference-done.
module roc_aer_sequencer #(
    parameter int IMAGE_SIZE  = 784,
    parameter int ADDR_BITS   = 10,
    parameter int CNT_BITS    = 10,
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_BITS     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 img_valid,
    output logic                 img_ready,
    output logic                 enc_new_image,
    input  logic                 enc_found_next_index,
    input  logic [ADDR_BITS-1:0] enc_next_index,
    input  logic                 enc_rdy,
    output logic                 enc_aerin_ctrl_busy,
    output logic                 enc_inference_rdy,
    output logic [ADDR_BITS-1:0] aerout_addr,
    output logic                 aerout_req,
    input  logic                 aerout_ack,
    input  logic                 core_inference_rdy,
    output logic                 done,
    output logic [CNT_BITS-1:0]  spike_count,
    output logic                 timeout_err
);

    if (CNT_BITS < $clog2(IMAGE_SIZE + 1)) begin : g_cnt_chk
        $error("CNT_BITS too narrow for IMAGE_SIZE");
    end
    if (TO_BITS < $clog2(ACK_TIMEOUT + 1) || ACK_TIMEOUT < 1) begin : g_to_chk
        $error("TO_BITS too narrow for ACK_TIMEOUT");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDX,
        ACK_HI,
        ACK_LO,
        WAIT_INF,
        FINISH
    } state_t;

    state_t               state, state_d;
    logic [TO_BITS-1:0]   to_cnt, to_cnt_d;
    logic [ADDR_BITS-1:0] addr_d;
    logic [CNT_BITS-1:0]  cnt_d;
    logic                 req_d, busy_d, new_img_d, inf_rdy_d, done_d, terr_d;
    logic                 to_hit, cnt_sat;

    // The counter holds (cycles spent in the phase - 1), so hitting TIMEOUT-1 on an
    // edge means the phase has lasted exactly ACK_TIMEOUT cycles.
    assign to_hit    = (to_cnt == TO_BITS'(ACK_TIMEOUT - 1));
    assign cnt_sat   = (spike_count == {CNT_BITS{1'b1}});
    assign img_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            to_cnt              <= '0;
            aerout_addr         <= '0;
            aerout_req          <= 1'b0;
            enc_aerin_ctrl_busy <= 1'b0;
            enc_new_image       <= 1'b0;
            enc_inference_rdy   <= 1'b0;
            done                <= 1'b0;
            spike_count         <= '0;
            timeout_err         <= 1'b0;
        end else begin
            state               <= state_d;
            to_cnt              <= to_cnt_d;
            aerout_addr         <= addr_d;
            aerout_req          <= req_d;
            enc_aerin_ctrl_busy <= busy_d;
            enc_new_image       <= new_img_d;
            enc_inference_rdy   <= inf_rdy_d;
            done                <= done_d;
            spike_count         <= cnt_d;
            timeout_err         <= terr_d;
        end
    end

    always_comb begin
        state_d   = state;
        to_cnt_d  = to_cnt;
        addr_d    = aerout_addr;
        req_d     = aerout_req;
        busy_d    = enc_aerin_ctrl_busy;
        new_img_d = 1'b0;
        inf_rdy_d = 1'b0;
        done_d    = 1'b0;
        cnt_d     = spike_count;
        terr_d    = timeout_err;
        case (state)
            IDLE: begin
                if (img_valid) begin
                    new_img_d = 1'b1;
                    cnt_d     = '0;
                    terr_d    = 1'b0;
                    state_d   = WAIT_IDX;
                end
            end
            WAIT_IDX: begin
                // A pending index is drained before the encoder's done is honoured.
                if (enc_found_next_index) begin
                    addr_d   = enc_next_index;
                    req_d    = 1'b1;
                    busy_d   = 1'b1;
                    to_cnt_d = '0;
                    state_d  = ACK_HI;
                end else if (enc_rdy) begin
                    state_d = WAIT_INF;
                end
            end
            ACK_HI: begin
                if (aerout_ack) begin
                    req_d    = 1'b0;
                    to_cnt_d = '0;
                    state_d  = ACK_LO;
                end else if (to_hit) begin
                    req_d   = 1'b0;
                    busy_d  = 1'b0;
                    terr_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    to_cnt_d = to_cnt + 1'b1;
                end
            end
            ACK_LO: begin
                if (!aerout_ack) begin
                    busy_d  = 1'b0;
                    cnt_d   = cnt_sat ? spike_count : spike_count + 1'b1;
                    state_d = WAIT_IDX;
                end else if (to_hit) begin
                    busy_d  = 1'b0;
                    terr_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    to_cnt_d = to_cnt + 1'b1;
                end
            end
            WAIT_INF: begin
                if (core_inference_rdy) begin
                    inf_rdy_d = 1'b1;
                    state_d   = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_roc_aer_sequencer.sv
// Directed bench for roc_aer_sequencer: encoder driven from one initial block,
// core AER responder/monitor records events, scoreboard queues check addresses.
module tb_roc_aer_sequencer;
    localparam int AB = 10;
    localparam int CB = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          img_valid = 1'b0;
    logic          img_ready;
    logic          enc_new_image;
    logic          enc_found_next_index = 1'b0;
    logic [AB-1:0] enc_next_index = '0;
    logic          enc_rdy = 1'b0;
    logic          enc_aerin_ctrl_busy;
    logic          enc_inference_rdy;
    logic [AB-1:0] aerout_addr;
    logic          aerout_req;
    logic          aerout_ack = 1'b0;
    logic          core_inference_rdy = 1'b0;
    logic          done;
    logic [CB-1:0] spike_count;
    logic          timeout_err;

    roc_aer_sequencer #(
        .IMAGE_SIZE(784), .ADDR_BITS(AB), .CNT_BITS(CB), .ACK_TIMEOUT(255), .TO_BITS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .img_valid(img_valid), .img_ready(img_ready),
        .enc_new_image(enc_new_image), .enc_found_next_index(enc_found_next_index),
        .enc_next_index(enc_next_index), .enc_rdy(enc_rdy),
        .enc_aerin_ctrl_busy(enc_aerin_ctrl_busy), .enc_inference_rdy(enc_inference_rdy),
        .aerout_addr(aerout_addr), .aerout_req(aerout_req), .aerout_ack(aerout_ack),
        .core_inference_rdy(core_inference_rdy), .done(done), .spike_count(spike_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Written only by the core model below
    logic [AB-1:0] obs_q[$];
    int            n_new = 0, n_inf = 0, n_done = 0, n_req_rise = 0, n_unstable = 0;
    int            cyc = 0, t_inf = 0, t_done = 0, ack_dly = 0;
    logic          prev_req = 1'b0;
    logic [AB-1:0] prev_addr = '0;

    // Written only by the main sequence
    logic [AB-1:0] exp_q[$];
    int            rd = 0;
    logic          ack_en = 1'b1;
    logic          hold_ack = 1'b0;

    // Core AER responder: ACK two samples after REQ rises, release after REQ drops
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            aerout_ack = 1'b0;
            ack_dly    = 0;
        end else begin
            if (aerout_req && !prev_req) begin
                n_req_rise++;
                if (ack_en) obs_q.push_back(aerout_addr);
            end
            if (aerout_req && prev_req && aerout_addr != prev_addr) n_unstable++;
            if (ack_en) begin
                if (aerout_req && !aerout_ack) begin
                    ack_dly++;
                    if (ack_dly >= 2) begin
                        aerout_ack = 1'b1;
                        ack_dly    = 0;
                    end
                end else if (!aerout_req && aerout_ack && !hold_ack) begin
                    aerout_ack = 1'b0;
                end
            end
            if (enc_new_image) n_new++;
            if (enc_inference_rdy) begin n_inf++; t_inf = cyc; end
            if (done) begin n_done++; t_done = cyc; end
        end
        prev_req  = aerout_req;
        prev_addr = aerout_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_img();
        @(negedge clk);
        img_valid = 1'b1;
        @(negedge clk);
        img_valid = 1'b0;
    endtask

    task automatic wait_busy(input logic v, input string tag);
        int n = 0;
        while (enc_aerin_ctrl_busy !== v && n < 50) begin @(negedge clk); n++; end
        chk(tag, 32'(enc_aerin_ctrl_busy), 32'(v));
    endtask

    task automatic sb_check(input string tag);
        logic [AB-1:0] e;
        e = exp_q.pop_front();
        if (obs_q.size() > rd) begin
            chk(tag, 32'(obs_q[rd]), 32'(e));
            rd++;
        end else begin
            chk({tag, "_missing"}, 32'(obs_q.size()), 32'(rd + 1));
        end
    endtask

    task automatic send_idx(input logic [AB-1:0] idx);
        enc_found_next_index = 1'b1;
        enc_next_index       = idx;
        exp_q.push_back(idx);
        wait_busy(1'b1, "busy_rise");
        wait_busy(1'b0, "busy_fall");
        sb_check("aer_addr");
    endtask

    task automatic wait_done(input int base, input string tag);
        int n = 0;
        while (n_done == base && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        chk(tag, 32'(n_done - base), 1);
    endtask

    initial begin
        int b_new, b_rise, b_inf, b_done, hi;
        logic [AB-1:0] seq [7];
        seq = '{10'd3, 10'd0, 10'd6, 10'd1, 10'd5, 10'd2, 10'd4};

        // 1: reset state
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(aerout_req), 0);
        chk("rst_busy", 32'(enc_aerin_ctrl_busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(spike_count), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        chk("rst_img_ready", 32'(img_ready), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2: start pulse, ignored second IMG_VALID
        b_new = n_new;
        start_img();
        repeat (3) @(negedge clk);
        chk("new_image_once", 32'(n_new - b_new), 1);
        chk("img_ready_busy", 32'(img_ready), 0);
        start_img();
        repeat (3) @(negedge clk);
        chk("new_image_ignored", 32'(n_new - b_new), 1);

        // 3: seven indices, then encoder/core completion
        b_rise = n_req_rise;
        foreach (seq[i]) send_idx(seq[i]);
        enc_found_next_index = 1'b0;
        repeat (2) @(negedge clk);
        chk("count_7", 32'(spike_count), 7);
        chk("req_rises_7", 32'(n_req_rise - b_rise), 7);
        b_inf = n_inf; b_done = n_done;
        enc_rdy = 1'b1;
        repeat (3) @(negedge clk);
        chk("wait_inf_hold", 32'(img_ready), 0);
        chk("no_early_done", 32'(n_done - b_done), 0);
        core_inference_rdy = 1'b1;
        wait_done(b_done, "done_once_3");
        chk("inf_rdy_once", 32'(n_inf - b_inf), 1);
        chk("inf_before_done", 32'(t_inf < t_done), 1);
        chk("img_ready_back", 32'(img_ready), 1);
        enc_rdy = 1'b0; core_inference_rdy = 1'b0;

        // 4: FOUND and ENC_RDY on the same edge
        start_img();
        enc_rdy = 1'b1;
        send_idx(10'd9);
        enc_found_next_index = 1'b0;
        repeat (3) @(negedge clk);
        chk("same_edge_wait_inf", 32'(img_ready), 0);
        chk("same_edge_count", 32'(spike_count), 1);
        b_done = n_done;
        core_inference_rdy = 1'b1;
        wait_done(b_done, "done_once_4");
        enc_rdy = 1'b0; core_inference_rdy = 1'b0;

        // 5: core never acknowledges
        start_img();
        send_idx(10'd2);
        ack_en = 1'b0;
        enc_next_index = 10'd5;
        hi = 0;
        while (aerout_req !== 1'b1 && hi < 10) begin @(negedge clk); hi++; end
        chk("to_req_rise", 32'(aerout_req), 1);
        hi = 0;
        while (aerout_req === 1'b1 && hi < 400) begin hi++; @(negedge clk); end
        chk("to_req_cycles", 32'(hi), 255);
        chk("to_busy", 32'(enc_aerin_ctrl_busy), 0);
        chk("to_err", 32'(timeout_err), 1);
        b_done = n_done;
        enc_found_next_index = 1'b0;
        wait_done(b_done, "done_timeout");
        chk("to_count", 32'(spike_count), 1);
        chk("to_err_sticky", 32'(timeout_err), 1);
        chk("to_img_ready", 32'(img_ready), 1);
        ack_en = 1'b1;

        // 6: reset while in ACK_LO
        start_img();
        chk("terr_cleared_on_start", 32'(timeout_err), 0);
        hold_ack = 1'b1;
        enc_found_next_index = 1'b1;
        enc_next_index = 10'd7;
        exp_q.push_back(10'd7);
        wait_busy(1'b1, "lo_busy_rise");
        hi = 0;
        while (aerout_req !== 1'b0 && hi < 20) begin @(negedge clk); hi++; end
        chk("lo_req_low", 32'(aerout_req), 0);
        chk("lo_ack_held", 32'(aerout_ack), 1);
        chk("lo_busy_held", 32'(enc_aerin_ctrl_busy), 1);
        sb_check("lo_addr");
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(enc_aerin_ctrl_busy), 0);
        chk("async_req", 32'(aerout_req), 0);
        enc_found_next_index = 1'b0;
        hold_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_img_ready", 32'(img_ready), 1);
        chk("post_rst_terr", 32'(timeout_err), 0);
        chk("post_rst_count", 32'(spike_count), 0);

        chk("addr_stable", 32'(n_unstable), 0);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
